// File: rtl/mult_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
// State encoding and step-counter sizing used by seq_mult and seq_mult_ctrl.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int cnt_w(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/seq_mult_if.sv
// Operand/product handshake bundle for seq_mult.
// in_signed exists only when SEQ_MULT_SIGNED_EN is defined.
interface seq_mult_if #(
  parameter int WIDTH = 8
);

  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
`ifdef SEQ_MULT_SIGNED_EN
  logic               in_signed;
`endif
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] p;

  modport master (
    output in_valid, a, b, out_ready,
`ifdef SEQ_MULT_SIGNED_EN
    output in_signed,
`endif
    input  in_ready, out_valid, p
  );

  modport slave (
    input  in_valid, a, b, out_ready,
`ifdef SEQ_MULT_SIGNED_EN
    input  in_signed,
`endif
    output in_ready, out_valid, p
  );

endinterface

// File: rtl/seq_mult_ctrl.sv
// IDLE/BUSY/DONE sequencer and step counter for seq_mult.
// One accept, WIDTH busy steps, then hold until the product is taken.
module seq_mult_ctrl
  import mult_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CW    = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic          out_ready,
  output logic          in_ready,
  output logic          out_valid,
  output logic          load,
  output logic          busy,
  output logic          last,
  output logic [CW-1:0] cnt
);

  state_t state;
  state_t nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= nxt;
      if (load)
        cnt <= '0;
      else if (busy)
        cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (in_valid)  nxt = BUSY;
      BUSY:    if (last)      nxt = DONE;
      DONE:    if (out_ready) nxt = IDLE;
      default:                nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (1'b1)
      (state == IDLE): in_ready  = 1'b1;
      (state == BUSY): busy      = 1'b1;
      (state == DONE): out_valid = 1'b1;
      default: ;
    endcase
    load = in_ready & in_valid;
    last = busy & (cnt == CW'(WIDTH - 1));
  end

endmodule

// File: rtl/seq_mult.sv
// Sequential shift-add multiplier, WIDTH cycles per product.
// Optional signed mode: define SEQ_MULT_SIGNED_EN.
module seq_mult
  import mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic     clk,
  input  logic     rst_n,
  seq_mult_if.slave bus
);

  localparam int CW = cnt_w(WIDTH);
  localparam int PW = 2 * WIDTH;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             neg;
  logic             neg_q;
  logic [PW-1:0]    acc;
  logic [PW-1:0]    p_q;
  logic [PW-1:0]    addend;
  logic [PW-1:0]    sum;
  logic [CW-1:0]    cnt;
  logic             load;
  logic             busy;
  logic             last;

  seq_mult_ctrl #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_ctrl (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (bus.in_valid),
    .out_ready (bus.out_ready),
    .in_ready  (bus.in_ready),
    .out_valid (bus.out_valid),
    .load      (load),
    .busy      (busy),
    .last      (last),
    .cnt       (cnt)
  );

`ifdef SEQ_MULT_SIGNED_EN
  // Magnitudes at accept; -2^(WIDTH-1) maps to 2^(WIDTH-1), still WIDTH bits.
  always_comb begin
    a_mag = (bus.in_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    b_mag = (bus.in_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;
    neg   = bus.in_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
  end
`else
  assign a_mag = bus.a;
  assign b_mag = bus.b;
  assign neg   = 1'b0;
`endif

  assign addend = PW'(a_q) << cnt;
  assign sum    = acc + (b_q[cnt] ? addend : '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      neg_q <= 1'b0;
      acc   <= '0;
      p_q   <= '0;
    end else if (load) begin
      a_q   <= a_mag;
      b_q   <= b_mag;
      neg_q <= neg;
      acc   <= '0;
    end else if (busy) begin
      acc <= sum;
      if (last)
        p_q <= neg_q ? -sum : sum;
    end
  end

  assign bus.p = p_q;

endmodule

// File: doc/seq_mult.md
SEQ_MULT -- requirements
Module: seq_mult

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits (legal range 2..32).
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port in_valid, input, 1, operand pair presented.
REQ-005 SHALL have port in_ready, output, 1, block can accept an operand pair.
REQ-006 SHALL have port a, input, WIDTH, multiplicand.
REQ-007 SHALL have port b, input, WIDTH, multiplier.
REQ-008 SHALL have port out_valid, output, 1, product valid.
REQ-009 SHALL have port out_ready, input, 1, consumer accepts product.
REQ-010 SHALL have port p, output, 2*WIDTH, product.

Function
REQ-011 SHALL implement FSM states IDLE, BUSY and DONE.
REQ-012 SHALL assert in_ready only in IDLE and out_valid only in DONE.
REQ-013 SHALL accept operands on an edge with in_valid and in_ready both high: latch a and b, clear the partial product and step counter, enter BUSY.
REQ-014 SHALL, in each BUSY cycle k (0..WIDTH-1), add (a_latched << k) to the 2*WIDTH-bit partial product when bit k of b_latched is 1; carries beyond 2*WIDTH are impossible and are not kept.
REQ-015 SHALL enter DONE after step WIDTH-1, so out_valid rises exactly WIDTH cycles after the accept edge (fixed latency, independent of data).
REQ-016 SHALL hold p and out_valid stable in DONE until an edge with out_ready high, then return to IDLE.
REQ-017 SHALL NOT accept new operands in the DONE-to-IDLE handoff cycle; the earliest next accept is the cycle after IDLE is re-entered.
REQ-018 SHALL ignore a, b and in_valid while in BUSY or DONE.
REQ-019 SHALL drive p to the last completed product in IDLE and BUSY, and to 0 before the first completion after reset.
REQ-020 SHALL produce correct results for the edge cases a=0 or b=0 (p=0) and all-ones operands (p=(2^WIDTH-1)^2).

Reset
REQ-021 SHALL, on rst_n low, immediately force state=IDLE, in_ready=1, out_valid=0, p=0, counter=0 and partial product=0, regardless of clock.
REQ-022 SHALL discard any in-flight operation when reset is asserted mid-BUSY or mid-DONE; no product is emitted for it.
REQ-023 SHALL accept operands on the first rising edge after rst_n deasserts.

Configuration
REQ-024 SHALL recognise the macro SEQ_MULT_SIGNED_EN.
REQ-025 SHALL, with SEQ_MULT_SIGNED_EN defined, add input port in_signed (1 bit, latched at accept); when it is 1, a and b are two's complement and p is the two's-complement product. The implementation converts each operand to its magnitude at accept and negates the result on the transition into DONE when the operand signs differ. Latency is unchanged.
REQ-026 SHALL handle -2^(WIDTH-1) operands correctly in signed mode (magnitude 2^(WIDTH-1) fits unsigned WIDTH).
REQ-027 SHALL, without SEQ_MULT_SIGNED_EN, omit in_signed and operate unsigned only.

Structure
REQ-028 SHALL take the FSM state enumeration (IDLE, BUSY, DONE) from shared package mult_pkg.
REQ-029 SHALL place the counter-width helper constant function (clog2 of WIDTH) in mult_pkg.
REQ-030 SHALL implement the FSM and step counter in one sub-module, seq_mult_ctrl; the add/shift datapath stays in seq_mult.

Verification
REQ-031 SHALL pass this scenario: WIDTH=8, a=3, b=5, out_ready=1 -> out_valid exactly 8 cycles after accept, p=15.
REQ-032 SHALL pass this scenario: WIDTH=8, a=255, b=255 -> p=65025; a=0, b=200 -> p=0.
REQ-033 SHALL pass this scenario: out_ready held low 5 cycles in DONE -> p and out_valid stable; in_ready stays 0; IDLE entered only after out_ready=1.
REQ-034 SHALL pass this scenario: rst_n pulsed low at BUSY step 4 -> out_valid never rises for that op; state is IDLE; the next op a=7, b=9 gives p=63.
REQ-035 SHALL pass this scenario (SEQ_MULT_SIGNED_EN, WIDTH=8, in_signed=1): -3*5 -> p=16'hFFF1; -128*-128 -> p=16384; 127*-128 -> p=16'hC080.
REQ-036 SHALL pass this scenario: 100 random back-to-back ops with in_valid held high -> every product matches the reference model, and spacing between accepts is WIDTH+2 cycles.
